// File: rtl/booth_mac_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | booth_mac_sequencer                                                    |
// | Feeds operand pairs to a sequential 8x8 Booth multiplier and           |
// | accumulates the products into a signed running sum.                    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module booth_mac_sequencer #(
  parameter int ACC_W    = 24,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_mc,
  input  logic [7:0]       in_mp,
  input  logic             in_last,
  output logic             mul_start,
  output logic [7:0]       mul_mc,
  output logic [7:0]       mul_mp,
  input  logic [15:0]      mul_out,
  input  logic             mul_busy,
  output logic [ACC_W-1:0] acc,
  output logic             acc_valid,
  output logic             ovf,
  output logic             err
);

  localparam int                    c_WCNT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [c_WCNT_W-1:0]   c_WAIT_LAST = c_WCNT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_last;
  logic                r_done;
  logic [c_WCNT_W-1:0] r_wcnt;

  logic [ACC_W-1:0]    w_prod_ext;
  logic [ACC_W-1:0]    w_sum;
  logic                w_ovf;

  assign w_prod_ext = {{(ACC_W-16){mul_out[15]}}, mul_out};
  assign w_sum      = acc + w_prod_ext;
  assign w_ovf      = (acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                      (w_sum[ACC_W-1] != acc[ACC_W-1]);
  assign in_ready   = (r_state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_wcnt    <= '0;
      acc       <= '0;
      acc_valid <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      mul_start <= 1'b0;
      mul_mc    <= '0;
      mul_mp    <= '0;
    end else begin
      acc_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            mul_mc    <= in_mc;
            mul_mp    <= in_mp;
            r_last    <= in_last;
            mul_start <= 1'b1;
            r_state   <= S_ISSUE;
            // First pair after a reported sum starts a fresh sequence.
            if (r_done) begin
              acc    <= '0;
              ovf    <= 1'b0;
              r_done <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          mul_start <= 1'b0;
          r_wcnt    <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          // The product is only present on the first busy-low sample.
          if (!mul_busy) begin
            acc     <= w_sum;
            r_state <= S_IDLE;
            if (w_ovf) begin
              ovf <= 1'b1;
            end
            if (r_last) begin
              acc_valid <= 1'b1;
              r_done    <= 1'b1;
            end
          end else if (r_wcnt == c_WAIT_LAST) begin
            err     <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_mac_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_booth_mac_sequencer                                                 |
// | Two accumulator widths side by side against a transaction-level model. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_booth_mac_sequencer;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [7:0]  in_mc = '0;
  logic [7:0]  in_mp = '0;

  logic        in_ready_a, in_ready_b, mul_start_a, mul_start_b;
  logic [7:0]  mul_mc_a, mul_mp_a, mul_mc_b, mul_mp_b;
  logic [15:0] mul_out;
  logic        mul_busy;
  logic [23:0] acc_a;
  logic [16:0] acc_b;
  logic        acc_valid_a, acc_valid_b, ovf_a, ovf_b, err_a, err_b;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  booth_mac_sequencer #(.ACC_W(24), .WAIT_MAX(WAIT_MAX)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_mc(in_mc), .in_mp(in_mp), .in_last(in_last),
    .mul_start(mul_start_a), .mul_mc(mul_mc_a), .mul_mp(mul_mp_a),
    .mul_out(mul_out), .mul_busy(mul_busy),
    .acc(acc_a), .acc_valid(acc_valid_a), .ovf(ovf_a), .err(err_a)
  );

  booth_mac_sequencer #(.ACC_W(17), .WAIT_MAX(WAIT_MAX)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_mc(in_mc), .in_mp(in_mp), .in_last(in_last),
    .mul_start(mul_start_b), .mul_mc(mul_mc_b), .mul_mp(mul_mp_b),
    .mul_out(mul_out), .mul_busy(mul_busy),
    .acc(acc_b), .acc_valid(acc_valid_b), .ovf(ovf_b), .err(err_b)
  );

  // Multiplier stand-in: product visible only while count==8, count wraps.
  logic [3:0]  s_cnt  = 4'd3;
  logic [15:0] s_prod = '0;
  bit          stuck  = 1'b0;

  function automatic logic [15:0] prod16(input logic [7:0] a, input logic [7:0] b);
    int x;
    x = int'($signed(a)) * int'($signed(b));
    return x[15:0];
  endfunction

  always @(posedge clk) begin
    if (mul_start_a) begin
      s_cnt  <= 4'd0;
      s_prod <= prod16(mul_mc_a, mul_mp_a);
    end else begin
      s_cnt <= s_cnt + 4'd1;
    end
  end

  assign mul_busy = stuck || (s_cnt != 4'd8);
  assign mul_out  = (s_cnt == 4'd8) ? s_prod : {s_cnt, 12'h5A5};

  // Transaction model: age counts clocks since acceptance (-1 = idle).
  int         age = -1;
  int         cyc = 0;
  int         acc_cyc[$];
  logic [7:0] m_mc = '0;
  logic [7:0] m_mp = '0;
  bit         m_last = 1'b0;
  bit         m_done = 1'b0;
  bit         m_err  = 1'b0;
  bit         m_av   = 1'b0;
  longint     m_acc[2] = '{0, 0};
  bit         m_ovf[2] = '{1'b0, 1'b0};
  int         wid[2]   = '{24, 17};

  function automatic longint wrapv(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = ((v % m) + m) % m;
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      age = -1; m_mc = '0; m_mp = '0; m_last = 1'b0; m_done = 1'b0;
      m_err = 1'b0; m_av = 1'b0;
      m_acc = '{0, 0}; m_ovf = '{1'b0, 1'b0};
    end else begin
      m_av = 1'b0;
      if (age < 0) begin
        if (in_valid) begin
          age = 0; m_mc = in_mc; m_mp = in_mp; m_last = in_last;
          acc_cyc.push_back(cyc);
          if (m_done) begin
            m_acc = '{0, 0}; m_ovf = '{1'b0, 1'b0}; m_done = 1'b0;
          end
        end
      end else if (!stuck && age == 9) begin
        for (int k = 0; k < 2; k++) begin
          longint s, hi;
          s  = m_acc[k] + longint'(int'($signed(m_mc)) * int'($signed(m_mp)));
          hi = (longint'(1) << (wid[k] - 1));
          if (s >= hi || s < -hi) m_ovf[k] = 1'b1;
          m_acc[k] = wrapv(s, wid[k]);
        end
        if (m_last) begin
          m_av = 1'b1; m_done = 1'b1;
        end
        age = -1;
      end else if (stuck && age == WAIT_MAX) begin
        m_err = 1'b1; age = -1;
      end else begin
        age++;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("in_ready_a", in_ready_a, age < 0);
      check("in_ready_b", in_ready_b, age < 0);
      check("mul_start", mul_start_a, age == 0);
      check("mul_start_b", mul_start_b, age == 0);
      check("mul_mc", mul_mc_a, m_mc);
      check("mul_mp", mul_mp_a, m_mp);
      check("mul_mc_b", mul_mc_b, m_mc);
      check("mul_mp_b", mul_mp_b, m_mp);
      check("acc_a", longint'($signed(acc_a)), m_acc[0]);
      check("acc_b", longint'($signed(acc_b)), m_acc[1]);
      check("ovf_a", ovf_a, m_ovf[0]);
      check("ovf_b", ovf_b, m_ovf[1]);
      check("acc_valid_a", acc_valid_a, m_av);
      check("acc_valid_b", acc_valid_b, m_av);
      check("err_a", err_a, m_err);
      check("err_b", err_b, m_err);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acc"}, acc_a, 0);
    check({tag, "_acc_b"}, acc_b, 0);
    check({tag, "_acc_valid"}, acc_valid_a, 0);
    check({tag, "_ovf"}, ovf_a | ovf_b, 0);
    check({tag, "_err"}, err_a | err_b, 0);
    check({tag, "_mul_start"}, mul_start_a, 0);
    check({tag, "_mul_ops"}, {mul_mc_a, mul_mp_a}, 0);
    check({tag, "_in_ready"}, in_ready_a, 1);
  endtask

  task automatic send(input logic [7:0] mc, input logic [7:0] mp, input logic last);
    int n;
    n = 0;
    @(negedge clk); #2;
    in_valid = 1'b1; in_mc = mc; in_mp = mp; in_last = last;
    while (!in_ready_a && n < 40) begin
      @(negedge clk); #2;
      n++;
    end
    if (n >= 40) check("send_timeout", n, 0);
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (age >= 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("idle_timeout", n, 0);
  endtask

  task automatic pair(input logic [7:0] mc, input logic [7:0] mp, input logic last);
    send(mc, mp, last);
    drop();
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int q;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    #2 rst = 1'b0;
    chk_en = 1'b1;

    pair(8'd3, 8'd5, 1'b1);
    check("single_acc", longint'($signed(acc_a)), 15);
    check("single_pulse", acc_valid_a, 1);

    pair(8'h80, 8'h80, 1'b0);
    pair(8'h7F, 8'h80, 1'b0);
    pair(8'hFF, 8'h01, 1'b1);
    check("dot3_acc", longint'($signed(acc_a)), 127);
    check("dot3_acc_b", longint'($signed(acc_b)), 127);
    check("dot3_ovf", ovf_a, 0);

    // Four maximal products are needed to leave the 17-bit range.
    repeat (3) pair(8'h80, 8'h80, 1'b0);
    pair(8'h80, 8'h80, 1'b1);
    check("wrap_acc_a", longint'($signed(acc_a)), 65536);
    check("wrap_acc_b", longint'($signed(acc_b)), -65536);
    check("wrap_ovf_b", ovf_b, 1);
    check("wrap_ovf_a", ovf_a, 0);
    pair(8'd1, 8'd1, 1'b1);
    check("ovf_clear_b", ovf_b, 0);
    check("ovf_clear_acc_b", longint'($signed(acc_b)), 1);

    pair(8'd2, 8'd2, 1'b0);
    @(negedge clk); stuck = 1'b1;
    pair(8'd5, 8'd5, 1'b1);
    @(negedge clk); stuck = 1'b0;
    check("wdog_err", err_a, 1);
    check("wdog_acc", longint'($signed(acc_a)), 4);
    check("wdog_ready", in_ready_a, 1);

    send(8'd7, 8'd7, 1'b0);
    drop();
    repeat (4) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midwait");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    pair(8'd2, 8'd3, 1'b1);
    check("post_rst_acc", longint'($signed(acc_a)), 6);
    check("post_rst_pulse", acc_valid_a, 1);

    q = acc_cyc.size();
    send(8'($urandom), 8'($urandom), 1'b0);
    send(8'($urandom), 8'($urandom), 1'b0);
    send(8'($urandom), 8'($urandom), 1'b1);
    drop();
    wait_idle();
    check("b2b_count", acc_cyc.size() - q, 3);
    if (acc_cyc.size() - q == 3) begin
      check("b2b_gap1", acc_cyc[q+1] - acc_cyc[q], 11);
      check("b2b_gap2", acc_cyc[q+2] - acc_cyc[q+1], 11);
    end

    for (int i = 0; i < 60; i++) begin
      send(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin
        drop();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drop();
    wait_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
